cc_frame_scheduler: RTL and testbench
=====================================

# cc_frame_scheduler

Atlas-bus command-and-control broadcaster on the master card. It owns one 54-bit C&C payload per address slot and shares the single serial C&C line among those slots. The payloads are time-multiplexed into 59-bit I2S-style frames framed by a generated CLRCLK. Updated slots are sent first, in round-robin order, and every frame is snapshotted at its start so a frame is never torn.

## Interface
- N_SLOTS, 4: number of address slots, 1..15; slot i transmits address i.
- IDLE_ADDR, 4'hF: address used in idle frames; no slot may use it.
- CBCLK  in  1: bit clock; all logic on its rising edge.
- reset  in  1: reset is synchronous and active-high.
- PTT  in  1: sampled at frame start into bit 58.
- slot_enable  in  N_SLOTS: slot may be transmitted.
- wr_en  in  1: payload write strobe.
- wr_slot  in  4: target slot; writes with wr_slot >= N_SLOTS are ignored.
- wr_data  in  54: payload, frame bits [53:0] (frequency, clock select, OC, mode, ADC and Alex fields).
- CLRCLK  out  1: frame clock, 64 CBCLK period, low half first.
- CC  out  1: serial C&C data, MSB first.
- pending  out  N_SLOTS: slot written but not yet sent.
- frame_start  out  1: one-cycle pulse in the first cycle of each frame.
- sent_slot  out  4: address carried by the current frame.

## Operation
- Free-running 6-bit phase counter `cnt`, wrapping 63 to 0.
- CLRCLK is registered: 0 for cnt 0..31, 1 for cnt 32..63.
- Frame word is 59 bits: {PTT, addr[3:0], payload[53:0]}.
- CC carries frame[59-cnt] for cnt 1..59, and 0 for cnt 0 and 60..63. Bit 58 is therefore valid at the second rising edge after CLRCLK falls.
- Frame-start edge (cnt 63 to 0) does all of the following:
  - selects the next slot;
  - snapshots PTT and the slot payload into the shift register;
  - clears that slot's pending bit;
  - pulses frame_start;
  - updates sent_slot.
- Selection is done by the picker:
  - Candidates are `pending & slot_enable`.
  - The first candidate at or after the round-robin pointer, circularly, is chosen.
  - The pointer then moves to selected+1 mod N_SLOTS.
- No candidate: behaviour depends on CC_REFRESH_EN (see Configuration).
- Writes:
  - wr_en stores wr_data into the live payload register and sets pending[wr_slot].
  - A write is never visible in a frame already started.
  - A write in the same cycle as the frame-start clear of that slot leaves pending set and stores the new data. The old snapshot is sent; the new data goes out in a later frame.
- Disabled slots keep their pending bit and are sent after they are enabled.
- A change to slot_enable takes effect at the next frame start.

## Timing
- Reset values:
  - cnt=32, CLRCLK=1, CC=0
  - pending=0, payloads=0, pointer=0
  - frame_start=0, sent_slot=IDLE_ADDR, shift register=0
- First CLRCLK falling edge occurs 32 CBCLK after reset deasserts.
- Latency from a write to first transmission is at most N_SLOTS frames once the slot is enabled, i.e. at most N_SLOTS*64 CBCLK plus the rest of the current frame.
- Reset asserted mid-frame aborts the frame immediately. CC=0 and CLRCLK=1 from the next edge; a partial frame is acceptable because receivers resynchronise on the next CLRCLK fall.
- Frame length is exactly 64 CBCLK, with no gaps or stretching.

## Configuration
- CC_REFRESH_EN defined: when no candidate exists, the picker runs round-robin over `slot_enable` alone and resends that slot's current payload, so receivers are refreshed continuously. If no slot is enabled, an idle frame is sent.
- CC_REFRESH_EN undefined: when no candidate exists, an idle frame is sent: addr=IDLE_ADDR, payload=0, PTT live.

## Structure
- Package cc_sched_pkg holds:
  - CC_FRAME_BITS=59, CC_PAYLOAD_BITS=54, CC_FRAME_CBCLKS=64;
  - CC_LOW_HALF=32, IDLE_ADDR default;
  - typedef cc_payload_t [53:0].
- Sub-module cc_rr_picker: combinational circular-priority picker; inputs request vector and pointer; outputs valid and index. It is used once, or twice when CC_REFRESH_EN is defined.

## Test plan
- Reset release, no writes, macro off: first CLRCLK fall at 32 CBCLK; receiver model decodes addr 4'hF, payload 0 every frame.
- Write slot 2 with 0x0_00D6_D800_0A5 and PTT=1, slot 2 enabled: next frame decodes PTT=1, addr 2, exact payload; pending[2] clears at frame_start.
- Write slots 0, 1, 3 in one frame: following frames send 0, 1, 3 in order; pointer then 0.
- Write slot 1 on the frame-start edge that selects slot 1: old payload sent, pending[1] stays 1, new payload sent in the next frame.
- Write slot 3 while slot_enable[3]=0: never sent and pending[3] held; enabling it yields transmission in the next frame.
- CC_REFRESH_EN defined, slots 0 and 2 enabled, nothing pending: frames alternate addr 0, 2; reset at cnt=40 gives CLRCLK=1 and CC=0 on the next edge.

Source files
------------

// File: rtl/cc_sched_pkg.sv
// cc_sched_pkg: shared constants and payload type for the C&C frame scheduler
package cc_sched_pkg;
  localparam int CC_FRAME_BITS = 59;
  localparam int CC_PAYLOAD_BITS = 54;
  localparam int CC_FRAME_CBCLKS = 64;
  localparam int CC_LOW_HALF = 32;
  localparam logic [3:0] CC_IDLE_ADDR = 4'hF;
  typedef logic [CC_PAYLOAD_BITS-1:0] cc_payload_t;
endpackage

// File: rtl/cc_rr_picker.sv
// cc_rr_picker: combinational circular-priority picker, first request at or after ptr
module cc_rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [3:0]   ptr,
  output logic         valid,
  output logic [3:0]   idx
);
  logic [N-1:0] rot;
  assign rot = N'({req, req} >> ptr);
  // scan from the farthest offset down so the request nearest the pointer wins
  always_comb begin
    valid = 1'b0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (rot[k]) begin
        valid = 1'b1;
        idx = (int'(ptr) + k >= N) ? 4'(int'(ptr) + k - N) : 4'(int'(ptr) + k);
      end
  end
endmodule

// File: rtl/cc_frame_scheduler.sv
// cc_frame_scheduler: round-robin C&C frame broadcaster; define CC_REFRESH_EN to resend enabled slots when nothing is pending
module cc_frame_scheduler
  import cc_sched_pkg::*;
#(
  parameter int         N_SLOTS   = 4,
  parameter logic [3:0] IDLE_ADDR = CC_IDLE_ADDR
) (
  input  logic               CBCLK,
  input  logic               reset,
  input  logic               PTT,
  input  logic [N_SLOTS-1:0] slot_enable,
  input  logic               wr_en,
  input  logic [3:0]         wr_slot,
  input  cc_payload_t        wr_data,
  output logic               CLRCLK,
  output logic               CC,
  output logic [N_SLOTS-1:0] pending,
  output logic               frame_start,
  output logic [3:0]         sent_slot
);
  logic [5:0] cnt, cnt_n;
  logic [3:0] ptr, p_idx, sel, addr;
  logic p_valid, sel_valid, fs;
  cc_payload_t pay [N_SLOTS];
  cc_payload_t snap;
  logic [CC_FRAME_BITS-1:0] sh;
  assign cnt_n = cnt + 6'd1;
  assign fs = cnt == 6'(CC_FRAME_CBCLKS - 1);
  cc_rr_picker #(.N(N_SLOTS)) u_pick (
    .req(pending & slot_enable), .ptr(ptr), .valid(p_valid), .idx(p_idx)
  );
`ifdef CC_REFRESH_EN
  logic r_valid;
  logic [3:0] r_idx;
  cc_rr_picker #(.N(N_SLOTS)) u_refresh (
    .req(slot_enable), .ptr(ptr), .valid(r_valid), .idx(r_idx)
  );
  assign sel_valid = p_valid | r_valid;
  assign sel = p_valid ? p_idx : r_idx;
`else
  assign sel_valid = p_valid;
  assign sel = p_idx;
`endif
  assign addr = sel_valid ? sel : IDLE_ADDR;
  // payload of the selected slot, zero for an idle frame
  always_comb begin
    snap = '0;
    for (int i = 0; i < N_SLOTS; i++)
      if (sel_valid && sel == 4'(i)) snap = pay[i];
  end
  // phase counter, frame clock, frame snapshot and MSB-first serialiser
  always_ff @(posedge CBCLK)
    if (reset) begin
      cnt <= 6'(CC_LOW_HALF);
      CLRCLK <= 1'b1;
      CC <= 1'b0;
      sh <= '0;
      frame_start <= 1'b0;
      sent_slot <= IDLE_ADDR;
      ptr <= '0;
    end else begin
      cnt <= cnt_n;
      CLRCLK <= cnt_n >= 6'(CC_LOW_HALF);
      frame_start <= fs;
      CC <= cnt < 6'(CC_FRAME_BITS) && sh[CC_FRAME_BITS-1];
      if (fs) begin
        sh <= {PTT, addr, snap};
        sent_slot <= addr;
        if (sel_valid) ptr <= (int'(sel) == N_SLOTS - 1) ? 4'd0 : sel + 4'd1;
      end else if (cnt < 6'(CC_FRAME_BITS)) sh <= sh << 1;
    end
  // live payloads and pending flags; a write beats the frame-start clear
  always_ff @(posedge CBCLK)
    for (int i = 0; i < N_SLOTS; i++)
      if (reset) begin
        pay[i] <= '0;
        pending[i] <= 1'b0;
      end else if (wr_en && wr_slot == 4'(i)) begin
        pay[i] <= wr_data;
        pending[i] <= 1'b1;
      end else if (fs && p_valid && p_idx == 4'(i)) pending[i] <= 1'b0;
endmodule

// File: tb/tb_cc_frame_scheduler.sv
// tb_cc_frame_scheduler: table and scoreboard bench with a CLRCLK/CC receiver model
module tb_cc_frame_scheduler;
  import cc_sched_pkg::*;
  localparam int N = 4;
  logic CBCLK = 1'b0, reset = 1'b1, PTT = 1'b0, wr_en = 1'b0;
  logic [N-1:0] slot_enable = '1;
  logic [3:0] wr_slot = '0;
  cc_payload_t wr_data = '0;
  logic CLRCLK, CC, frame_start;
  logic [N-1:0] pending;
  logic [3:0] sent_slot;
  int checks = 0, errors = 0, n;
  logic [58:0] exp_q[$];
  logic [58:0] rx, e;
  int rk = 59;
  logic prev_clr = 1'b1;
  typedef struct {
    logic [3:0]  slot;
    cc_payload_t data;
    logic        ptt;
    logic [3:0]  pend;
    logic        send;
  } vec_t;
  vec_t tbl[7];

  cc_frame_scheduler #(.N_SLOTS(N)) dut (
    .CBCLK(CBCLK), .reset(reset), .PTT(PTT), .slot_enable(slot_enable),
    .wr_en(wr_en), .wr_slot(wr_slot), .wr_data(wr_data), .CLRCLK(CLRCLK),
    .CC(CC), .pending(pending), .frame_start(frame_start), .sent_slot(sent_slot)
  );

  always #5 CBCLK = ~CBCLK;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  // receiver: resync on CLRCLK fall, shift in 59 bits, compare against scoreboard
  always @(negedge CBCLK) begin
    if (reset) rk = 59;
    else if (prev_clr && !CLRCLK) rk = 0;
    else if (rk < 59) begin
      rx = {rx[57:0], CC};
      rk++;
      if (rk == 59) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rx_frame", rx, e);
        end
`ifndef CC_REFRESH_EN
        else chk("rx_idle", rx[57:0], {4'hF, 54'h0});
`endif
      end
    end
    prev_clr = CLRCLK;
  end

  task automatic wait_fs();
    for (int i = 0; i < 200; i++) begin
      @(negedge CBCLK);
      if (frame_start) return;
    end
    checks++;
    errors++;
    $display("FAIL fs_timeout: no frame_start within 200 cycles");
  endtask

  task automatic tail();
    wait_fs();
    repeat (60) @(negedge CBCLK);
  endtask

  task automatic wr(input logic [3:0] s, input cc_payload_t d);
    wr_en = 1'b1;
    wr_slot = s;
    wr_data = d;
    @(negedge CBCLK);
    wr_en = 1'b0;
  endtask

  initial begin
    tbl[0] = '{4'd2, 54'h00D6D8000A5, 1'b1, 4'b0100, 1'b1};
    tbl[1] = '{4'd0, 54'h3F_FFFF_FFFF_FFFF, 1'b0, 4'b0001, 1'b1};
    tbl[2] = '{4'd1, 54'h2A_AAAA_AAAA_AAAA, 1'b1, 4'b0010, 1'b1};
    tbl[3] = '{4'd5, 54'h123, 1'b0, 4'b0000, 1'b0};
    tbl[4] = '{4'd2, 54'h1, 1'b0, 4'b0100, 1'b1};
    tbl[5] = '{4'd15, 54'h3F_0000_0000_00FF, 1'b0, 4'b0000, 1'b0};
    tbl[6] = '{4'd3, 54'h15_5555_5555_5555, 1'b0, 4'b1000, 1'b1};
`ifdef CC_REFRESH_EN
    slot_enable = 4'b0101;
`endif
    repeat (3) @(negedge CBCLK);
    chk("rst_clrclk", CLRCLK, 1);
    chk("rst_cc", CC, 0);
    chk("rst_pending", pending, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_sent_slot", sent_slot, 4'hF);
    reset = 1'b0;
    n = 0;
    do begin
      @(negedge CBCLK);
      n++;
    end while (CLRCLK && n < 100);
    chk("first_fall", n, 32);
    chk("first_frame_start", frame_start, 1);
`ifdef CC_REFRESH_EN
    chk("refresh_sent0", sent_slot, 0);
    for (int i = 0; i < 3; i++) begin
      wait_fs();
      chk("refresh_sent", sent_slot, (i % 2 == 0) ? 2 : 0);
    end
`else
    chk("first_sent_idle", sent_slot, 4'hF);
    foreach (tbl[i]) begin
      tail();
      PTT = tbl[i].ptt;
      wr(tbl[i].slot, tbl[i].data);
      chk("tbl_pend_set", pending, tbl[i].pend);
      if (tbl[i].send) exp_q.push_back({tbl[i].ptt, tbl[i].slot, tbl[i].data});
      wait_fs();
      PTT = 1'b0;
      chk("tbl_pend_clr", pending, 0);
      chk("tbl_sent", sent_slot, tbl[i].send ? tbl[i].slot : 4'hF);
    end
    tail();
    wr(0, 54'h11);
    wr(1, 54'h2_2222_2222);
    wr(3, 54'h33_0000_0033);
    chk("multi_pend", pending, 4'b1011);
    exp_q.push_back({1'b0, 4'd0, 54'h11});
    exp_q.push_back({1'b0, 4'd1, 54'h2_2222_2222});
    exp_q.push_back({1'b0, 4'd3, 54'h33_0000_0033});
    wait_fs();
    chk("rr_sent_0", sent_slot, 0);
    wait_fs();
    chk("rr_sent_1", sent_slot, 1);
    wait_fs();
    chk("rr_sent_3", sent_slot, 3);
    repeat (60) @(negedge CBCLK);
    wr(3, 54'h3E3);
    wr(0, 54'h0E0);
    exp_q.push_back({1'b0, 4'd0, 54'h0E0});
    exp_q.push_back({1'b0, 4'd3, 54'h3E3});
    wait_fs();
    chk("ptr_wrap_first", sent_slot, 0);
    wait_fs();
    chk("ptr_wrap_second", sent_slot, 3);
    repeat (60) @(negedge CBCLK);
    wr(1, 54'hA0A0);
    exp_q.push_back({1'b0, 4'd1, 54'hA0A0});
    exp_q.push_back({1'b0, 4'd1, 54'hB0B0});
    repeat (2) @(negedge CBCLK);
    wr(1, 54'hB0B0);
    chk("edge_frame_start", frame_start, 1);
    chk("edge_sent", sent_slot, 1);
    chk("edge_pend_kept", pending[1], 1);
    wait_fs();
    chk("edge_resent", sent_slot, 1);
    chk("edge_pend_clr", pending[1], 0);
    repeat (60) @(negedge CBCLK);
    slot_enable = 4'b0111;
    wr(3, 54'hD15);
    tail();
    tail();
    chk("disabled_pend_held", pending, 4'b1000);
    slot_enable = 4'b1111;
    exp_q.push_back({1'b0, 4'd3, 54'hD15});
    wait_fs();
    chk("enabled_sent", sent_slot, 3);
    chk("enabled_pend_clr", pending, 0);
`endif
    repeat (60) @(negedge CBCLK);
    wr(0, 54'h3F_FFFF_FFFF_FFFF);
    wait_fs();
    repeat (40) @(negedge CBCLK);
    chk("pre_reset_cc", CC, 1);
    reset = 1'b1;
    @(negedge CBCLK);
    chk("mid_reset_clrclk", CLRCLK, 1);
    chk("mid_reset_cc", CC, 0);
    chk("mid_reset_sent", sent_slot, 4'hF);
    reset = 1'b0;
    repeat (100) @(negedge CBCLK);
    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
